// File: rtl/output_serializer_pkg.sv
// Shared types for the output serializer: emit FSM state,
// group metadata and the lane-clipping helper.
package output_serializer_pkg;

  localparam int LANES_PER_GROUP = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } emit_state_e;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ch;
    logic [1:0]  nlanes;
  } grp_meta_t;

  // Lanes of a group that fall below the channel limit; 0 drops it.
  function automatic logic [1:0] clip_lanes(
    input logic [31:0] ch,
    input logic [31:0] nb
  );
    logic [31:0] rem;
    rem = nb - ch;
    if (ch >= nb) return 2'd0;
    if (rem >= 32'd3) return 2'd3;
    return rem[1:0];
  endfunction

endpackage

// File: rtl/output_serializer_group_fifo.sv
// Registered group FIFO: one entry per 3-lane group plus metadata,
// head entry read combinationally from storage.
module group_fifo
  import output_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int GW = LANES_PER_GROUP * DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_in,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [GW-1:0] wdata_i,
  input  grp_meta_t     wmeta_i,
  output logic [GW-1:0] rdata_o,
  output grp_meta_t     rmeta_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  typedef struct packed {
    logic [GW-1:0] data;
    grp_meta_t     meta;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= '{data: wdata_i, meta: wmeta_i};
  end

  assign rdata_o = mem_q[rptr_q].data;
  assign rmeta_o = mem_q[rptr_q].meta;
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/output_serializer.sv
// Buffers 3-lane output groups and serializes them one channel
// per word onto the host valid/ready handshake.
module output_serializer
  import output_serializer_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int GROUP_FIFO_DEPTH   = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_in,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [LANES_PER_GROUP*DATA_WIDTH-1:0]   in_data,
  input  logic [31:0]                             in_x,
  input  logic [31:0]                             in_y,
  input  logic [31:0]                             in_ch,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATA_WIDTH-1:0]                   out_data,
  output logic [31:0]                             out_x,
  output logic [31:0]                             out_y,
  output logic [31:0]                             out_ch,
  output logic                                    fifo_empty,
  output logic                                    overflow
);

  localparam int CW = $clog2(GROUP_FIFO_DEPTH) + 1;
  localparam int GW = LANES_PER_GROUP * DATA_WIDTH;

  emit_state_e   state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic          overflow_q;
  logic [1:0]    nlanes;
  grp_meta_t     wmeta, rmeta;
  logic [GW-1:0] rdata;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop, fire, last;

  assign nlanes = clip_lanes(in_ch, 32'(OUTPUT_NB_CHANNELS));
  assign wmeta  = '{x: in_x, y: in_y, ch: in_ch, nlanes: nlanes};

  assign in_ready = !full;
  assign push     = in_valid && in_ready && (nlanes != 2'd0);
  assign fire     = (state_q == EMIT) && out_ready;
  assign last     = (lane_q == rmeta.nlanes - 2'd1);
  assign pop      = fire && last;

  group_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (GROUP_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_in  (rst_in),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_data),
    .wmeta_i (wmeta),
    .rdata_o (rdata),
    .rmeta_o (rmeta),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q    <= IDLE;
      lane_q     <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      if (in_valid && !in_ready) overflow_q <= 1'b1;
    end
  end

  // Stay in EMIT across a pop if another group remains after this edge.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = EMIT;
          lane_d  = 2'd0;
        end
      end
      EMIT: begin
        if (fire) begin
          if (!last) begin
            lane_d = lane_q + 2'd1;
          end else begin
            lane_d = 2'd0;
            if (count == CW'(1) && !push) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_x     = '0;
    out_y     = '0;
    out_ch    = '0;
    if (state_q == EMIT) begin
      out_valid = 1'b1;
      out_x     = rmeta.x;
      out_y     = rmeta.y;
      out_ch    = rmeta.ch + 32'(lane_q);
      case (lane_q)
        2'd0:    out_data = rdata[0*DATA_WIDTH +: DATA_WIDTH];
        2'd1:    out_data = rdata[1*DATA_WIDTH +: DATA_WIDTH];
        2'd2:    out_data = rdata[2*DATA_WIDTH +: DATA_WIDTH];
        default: out_data = '0;
      endcase
    end
  end

  assign fifo_empty = empty;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer: vector table plus
// back-pressure, full-FIFO, push/pop overlap and reset sequences.
module tb_output_serializer;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic [31:0] in_x, in_y, in_ch;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_x, out_y, out_ch;
  logic        fifo_empty;
  logic        overflow;

  int total = 0;
  int passed = 0;

  output_serializer #(
    .DATA_WIDTH         (32),
    .OUTPUT_NB_CHANNELS (64),
    .GROUP_FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_ch      (in_ch),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_ch     (out_ch),
    .fifo_empty (fifo_empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ch;
    logic [31:0] d0;
    int          exp_n;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic check_word(input string nm, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] ch,
                            input logic [31:0] d);
    total++;
    if (out_valid === 1'b1 && out_x === x && out_y === y &&
        out_ch === ch && out_data === d)
      passed++;
    else
      $display("FAIL %s: got v=%0b x=%0h y=%0h ch=%0h d=%0h expected v=1 x=%0h y=%0h ch=%0h d=%0h",
               nm, out_valid, out_x, out_y, out_ch, out_data, x, y, ch, d);
  endtask

  task automatic set_group(input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] ch, input logic [31:0] d0);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_ch    = ch;
    in_data  = {d0 + 32'd2, d0 + 32'd1, d0};
  endtask

  task automatic push(input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] ch, input logic [31:0] d0);
    set_group(x, y, ch, d0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    vecs[0] = '{x: 2,  y: 5,  ch: 0,  d0: 10,  exp_n: 3};
    vecs[1] = '{x: 7,  y: 1,  ch: 61, d0: 100, exp_n: 3};
    vecs[2] = '{x: 3,  y: 3,  ch: 62, d0: 200, exp_n: 2};
    vecs[3] = '{x: 4,  y: 4,  ch: 63, d0: 300, exp_n: 1};
    vecs[4] = '{x: 9,  y: 9,  ch: 64, d0: 400, exp_n: 0};
    vecs[5] = '{x: 8,  y: 8,  ch: 66, d0: 500, exp_n: 0};
    vecs[6] = '{x: 32'hDEADBEEF, y: 32'h12345678, ch: 30,
                d0: 32'hFFFF_FFFE, exp_n: 3};
    vecs[7] = '{x: 1,  y: 2,  ch: 32'hFFFF_FFFF, d0: 1, exp_n: 0};

    rst_in    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_x      = '0;
    in_y      = '0;
    in_ch     = '0;
    out_ready = 1'b0;
    tick();
    tick();

    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_fifo_empty", 32'(fifo_empty), 1);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_ch", out_ch, 0);
    rst_in = 1'b0;

    // Vector table: single groups with host always ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].x, vecs[i].y, vecs[i].ch, vecs[i].d0);
      check($sformatf("v%0d_empty_after_push", i), 32'(fifo_empty),
            (vecs[i].exp_n == 0) ? 32'd1 : 32'd0);
      check($sformatf("v%0d_latency", i), 32'(out_valid), 0);
      tick();
      for (int k = 0; k < vecs[i].exp_n; k++) begin
        check_word($sformatf("v%0d_word%0d", i, k), vecs[i].x, vecs[i].y,
                   vecs[i].ch + 32'(k), vecs[i].d0 + 32'(k));
        tick();
      end
      check($sformatf("v%0d_done_valid", i), 32'(out_valid), 0);
      check($sformatf("v%0d_done_empty", i), 32'(fifo_empty), 1);
    end

    // Back pressure: two groups held for 10 cycles, then drained
    out_ready = 1'b0;
    push(6, 6, 0, 20);
    push(6, 6, 3, 23);
    for (int c = 0; c < 10; c++) begin
      check_word($sformatf("bp_hold%0d", c), 6, 6, 0, 20);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check_word($sformatf("bp_word%0d", k), 6, 6, 32'(k), 32'(20 + k));
      tick();
    end
    check("bp_done_valid", 32'(out_valid), 0);
    check("bp_done_empty", 32'(fifo_empty), 1);

    // Push on the last lane of the head while it pops
    push(11, 12, 0, 70);
    tick();
    check_word("ov_a0", 11, 12, 0, 70);
    tick();
    check_word("ov_a1", 11, 12, 1, 71);
    tick();
    check_word("ov_a2", 11, 12, 2, 72);
    set_group(13, 14, 3, 80);
    tick();
    in_valid = 1'b0;
    check("ov_not_empty", 32'(fifo_empty), 0);
    check_word("ov_b0", 13, 14, 3, 80);
    tick();
    check_word("ov_b1", 13, 14, 4, 81);
    tick();
    check_word("ov_b2", 13, 14, 5, 82);
    tick();
    check("ov_done_empty", 32'(fifo_empty), 1);
    check("ov_done_valid", 32'(out_valid), 0);

    // Full FIFO: five offers into depth 4 with host stalled
    out_ready = 1'b0;
    for (int g = 0; g < 5; g++) begin
      check($sformatf("full_in_ready_before%0d", g), 32'(in_ready),
            (g < 4) ? 32'd1 : 32'd0);
      check($sformatf("full_overflow_before%0d", g), 32'(overflow), 0);
      push(32'(g), 32'(g + 1), 32'(3 * g), 32'(1000 + 3 * g));
    end
    check("full_overflow_set", 32'(overflow), 1);
    check("full_in_ready_low", 32'(in_ready), 0);
    out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 3; k++) begin
        check_word($sformatf("full_g%0d_w%0d", g, k), 32'(g), 32'(g + 1),
                   32'(3 * g + k), 32'(1000 + 3 * g + k));
        tick();
      end
    end
    check("full_done_valid", 32'(out_valid), 0);
    check("full_done_empty", 32'(fifo_empty), 1);
    check("full_overflow_sticky", 32'(overflow), 1);

    // Reset in the middle of a group
    push(21, 22, 0, 600);
    tick();
    check_word("mr_w0", 21, 22, 0, 600);
    tick();
    check_word("mr_w1", 21, 22, 1, 601);
    do_reset();
    check("mr_valid", 32'(out_valid), 0);
    check("mr_empty", 32'(fifo_empty), 1);
    check("mr_overflow", 32'(overflow), 0);
    tick();
    check("mr_still_idle", 32'(out_valid), 0);
    push(23, 24, 6, 90);
    tick();
    check_word("mr_d0", 23, 24, 6, 90);
    tick();
    check_word("mr_d1", 23, 24, 7, 91);
    tick();
    check_word("mr_d2", 23, 24, 8, 92);
    tick();
    check("mr_done_empty", 32'(fifo_empty), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/output_serializer.md
# output_serializer

Sits directly downstream of the convolution controller/output shift stage. Accepts one 3-channel group of finished output sums per input beat (tagged with x, y and base channel) and serializes each group into single-word beats on the host output handshake, one channel per word. A small group FIFO absorbs the back-to-back groups produced during each compute window (two groups per pixel, base channels ch and ch+3), so host back-pressure does not lose data.

## Interface
Parameters:
- DATA_WIDTH, 32: width of one output sum.
- OUTPUT_NB_CHANNELS, 64: total output channels; lanes at or above this are dropped.
- GROUP_FIFO_DEPTH, 4: number of 3-lane groups buffered; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_in  in  1  reset; synchronous, active-high.
- in_valid  in  1  group present on in_*.
- in_ready  out  1  FIFO can accept a group this cycle.
- in_data  in  3*DATA_WIDTH  lane 0 in bits [DATA_WIDTH-1:0], lane k at channel in_ch+k.
- in_x, in_y, in_ch  in  32 each  pixel coordinates and base channel of the group.
- out_valid  out  1  word present on out_*.
- out_ready  in  1  host accepts word.
- out_data  out  DATA_WIDTH  serialized sum.
- out_x, out_y, out_ch  out  32 each  coordinates and channel of out_data.
- fifo_empty  out  1  no group buffered and no word pending.
- overflow  out  1  sticky: a group was offered while in_ready=0.

## Operation
- Push: in_valid && in_ready writes {in_data, in_x, in_y, in_ch, nlanes} to FIFO tail, where nlanes = min(3, OUTPUT_NB_CHANNELS - in_ch), computed at 32-bit unsigned width.
- Group with in_ch >= OUTPUT_NB_CHANNELS (nlanes <= 0): accepted but not written; occupancy unchanged.
- in_ready = occupancy != GROUP_FIFO_DEPTH; no same-cycle bypass of a pop into a full FIFO.
- Overflow: in_valid && !in_ready sets overflow; the group is dropped; cleared only by rst_in.
- Emit FSM, states IDLE, EMIT:
  - IDLE: out_valid=0; FIFO non-empty -> EMIT with lane=0.
  - EMIT: out_valid=1; out_data = head lane[lane], out_x/out_y = head x/y, out_ch = head ch + lane.
  - On out_valid && out_ready: lane < nlanes-1 -> lane+1; else pop head, lane=0, stay in EMIT if another group remains (after this cycle's push/pop), else IDLE.
- out_* stable while out_valid && !out_ready.
- Occupancy: +1 on effective push, -1 on pop, both in same cycle -> unchanged.
- fifo_empty = occupancy==0.

## Timing
- Reset (rst_in=1 at edge): occupancy 0, pointers 0, lane 0, state IDLE, overflow 0. Outputs after reset: out_valid 0, in_ready 1, fifo_empty 1, overflow 0, out_data/out_x/out_y/out_ch 0.
- Reset mid-operation discards all buffered groups; no partial group is emitted afterwards.
- Latency: group pushed at edge N -> first word out_valid in cycle after N (edge N+1 state EMIT); no combinational path from in_* to out_*.
- Throughput: one word per cycle with out_ready held high; a full group of 3 lanes drains in 3 cycles, back-to-back groups without bubbles.
- in_ready depends only on registered occupancy.
- Pointers wrap modulo GROUP_FIFO_DEPTH.

## Structure
- Shared package output_serializer_pkg: emit state typedef (IDLE, EMIT), LANES_PER_GROUP=3, group entry struct (data lanes, x, y, ch, 2-bit nlanes).
- One sub-module: group_fifo (synchronous, registered storage, push/pop/occupancy, first-word read combinational from storage); emit FSM and lane counter in top.

## Test plan
- Reset then one group {x=2,y=5,ch=0,data=10,11,12}, out_ready=1 -> words (2,5,0,10),(2,5,1,11),(2,5,2,12) on three consecutive cycles starting one cycle after push; fifo_empty=1 after.
- Back pressure: push groups ch=0 and ch=3, hold out_ready=0 for 10 cycles -> out_valid=1 with out_ch=0 held stable; release -> six words ch 0..5 in order, no gaps.
- Clipping with OUTPUT_NB_CHANNELS=64: group ch=63 -> single word ch=63; group ch=66 -> no words, occupancy unchanged.
- Full FIFO: out_ready=0, push 5 groups at depth 4 -> in_ready=0 after 4th, overflow=1 after 5th, only groups 1..4 emitted once out_ready=1.
- Simultaneous push/pop at occupancy 1 on last lane of head -> occupancy stays 1, next group follows without bubble.
- Assert rst_in while EMIT mid-group (lane=1) -> next cycle out_valid=0, fifo_empty=1, overflow=0; subsequent group emits from lane 0.
